// File: rtl/mem_xlate_ctrl_pkg.sv
// Shared types and constants for the MEM-stage translation/bus controller.
package mem_xlate_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XLATE,
    BUS,
    RESP
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  // Size code 3 behaves as a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_xlate_ctrl_lane_align.sv
// Byte-lane enables, store-data replication and load extraction/extension.
module mem_lane_align
  import mem_xlate_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lo_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  always_comb begin
    sel_o   = '0;
    wdata_o = '0;
    rdata_o = '0;
    byte_l  = '0;
    half_l  = '0;
    case (size_i)
      SIZE_B: begin
        sel_o   = 4'b0001 << lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        byte_l  = rdata_i[{lo_i, 3'b000} +: 8];
        rdata_o = {{24{signed_i & byte_l[7]}}, byte_l};
      end
      SIZE_H: begin
        sel_o   = lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        half_l  = lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        rdata_o = {{16{signed_i & half_l[15]}}, half_l};
      end
      default: begin
        sel_o   = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_xlate_ctrl.sv
// MEM-stage access controller: TLB translation, MIPS address/TLB exceptions, one bus transaction.
// Optional bus-ack timeout (DBE exception) enabled by defining BUS_TIMEOUT_EN.
module mem_xlate_ctrl
  import mem_xlate_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_vaddr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] tlb_vaddr,
  output logic        tlb_we,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_valid,
  input  logic        tlb_miss,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_badvaddr
);

  state_e      state_q;
  logic [31:0] vaddr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [31:0] paddr_q;
  logic        flush_q;
  logic [31:0] rdata_q;
  logic        exc_valid_q;
  logic [4:0]  exc_code_q;
  logic [31:0] exc_badvaddr_q;

  logic        accept;
  logic        fault_d;
  logic [4:0]  fault_code_d;
  logic        in_bus;
  logic [3:0]  sel_w;
  logic [31:0] wrep_w;
  logic [31:0] load_w;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  mem_lane_align u_align (
    .size_i   (size_q),
    .lo_i     (paddr_q[1:0]),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .rdata_i  (bus_rdata),
    .sel_o    (sel_w),
    .wdata_o  (wrep_w),
    .rdata_o  (load_w)
  );

  always_comb begin
    fault_d      = 1'b0;
    fault_code_d = '0;
    if (misaligned(size_q, vaddr_q[1:0])) begin
      fault_d      = 1'b1;
      fault_code_d = we_q ? EXC_ADES : EXC_ADEL;
    end else if (!tlb_valid) begin
      fault_d      = 1'b1;
      fault_code_d = tlb_miss ? (we_q ? EXC_TLBS : EXC_TLBL) : EXC_MOD;
    end
  end

  // The exception pulse cycle sits in IDLE, so acceptance waits one more cycle.
  assign accept = !reset && (state_q == IDLE) && req_valid && !flush && !exc_valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      vaddr_q        <= '0;
      we_q           <= 1'b0;
      size_q         <= SIZE_B;
      signed_q       <= 1'b0;
      wdata_q        <= '0;
      paddr_q        <= '0;
      flush_q        <= 1'b0;
      rdata_q        <= '0;
      exc_valid_q    <= 1'b0;
      exc_code_q     <= '0;
      exc_badvaddr_q <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      exc_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          vaddr_q  <= req_vaddr;
          we_q     <= req_we;
          size_q   <= req_size;
          signed_q <= req_signed;
          wdata_q  <= req_wdata;
          flush_q  <= 1'b0;
          state_q  <= XLATE;
        end
        XLATE: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (fault_d) begin
            exc_valid_q    <= 1'b1;
            exc_code_q     <= fault_code_d;
            exc_badvaddr_q <= vaddr_q;
            state_q        <= IDLE;
          end else begin
            paddr_q <= tlb_paddr;
            state_q <= BUS;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        BUS: begin
          if (bus_ack) begin
            rdata_q <= we_q ? '0 : load_w;
            flush_q <= 1'b0;
            state_q <= (flush || flush_q) ? IDLE : RESP;
          end else begin
`ifdef BUS_TIMEOUT_EN
            if (timeout) begin
              flush_q <= 1'b0;
              state_q <= IDLE;
              if (!(flush || flush_q)) begin
                exc_valid_q    <= 1'b1;
                exc_code_q     <= EXC_DBE;
                exc_badvaddr_q <= vaddr_q;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (flush) flush_q <= 1'b1;
            end
`else
            if (flush) flush_q <= 1'b1;
`endif
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_bus       = (state_q == BUS);
  assign stall        = accept || (state_q == XLATE) || in_bus;
  assign tlb_vaddr    = vaddr_q;
  assign tlb_we       = we_q;
  assign bus_req      = in_bus;
  assign bus_we       = in_bus && we_q;
  assign bus_addr     = in_bus ? {paddr_q[31:2], 2'b00} : '0;
  assign bus_sel      = in_bus ? sel_w : '0;
  assign bus_wdata    = in_bus ? wrep_w : '0;
  assign resp_valid   = (state_q == RESP) && !flush;
  assign resp_rdata   = rdata_q;
  assign exc_valid    = exc_valid_q;
  assign exc_code     = exc_code_q;
  assign exc_badvaddr = exc_badvaddr_q;

endmodule

// File: tb/tb_mem_xlate_ctrl.sv
// Scoreboard bench for mem_xlate_ctrl: arithmetic reference model, bus responder and pulse monitor.
module tb_mem_xlate_ctrl;

  localparam int unsigned TMO   = 8;
  localparam int unsigned NEVER = 1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_signed, flush;
  logic [1:0]  req_size;
  logic [31:0] req_vaddr, req_wdata;
  logic        stall;
  logic [31:0] tlb_vaddr, tlb_paddr;
  logic        tlb_we, tlb_valid, tlb_miss;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic        resp_valid, exc_valid;
  logic [31:0] resp_rdata, exc_badvaddr;
  logic [4:0]  exc_code;
  logic [31:0] tlb_xor;

  always #5 clock = ~clock;

  // Behavioural TLB: fixed page-number remap, offset preserved.
  assign tlb_paddr = tlb_vaddr ^ tlb_xor;

  mem_xlate_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_vaddr(req_vaddr),
    .req_wdata(req_wdata), .flush(flush), .stall(stall), .tlb_vaddr(tlb_vaddr),
    .tlb_we(tlb_we), .tlb_paddr(tlb_paddr), .tlb_valid(tlb_valid), .tlb_miss(tlb_miss),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_badvaddr(exc_badvaddr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        we;
    int unsigned delay;
    logic [31:0] rdata;
  } bus_t;

  typedef struct {
    logic        is_exc;
    logic [31:0] data;
    logic [4:0]  code;
    logic [31:0] badvaddr;
    int unsigned lat;
  } pulse_t;

  bus_t        bus_q[$];
  pulse_t      sb_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned accept_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({stall, tlb_we, bus_req, bus_we, bus_sel, resp_valid, exc_valid, exc_code}), 32'd0);
    check({tag, "_tlb_vaddr"}, tlb_vaddr, 32'd0);
    check({tag, "_bus_addr"}, bus_addr, 32'd0);
    check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_badvaddr"}, exc_badvaddr, 32'd0);
  endtask

  // Bus responder: acks after the requested number of cycles, checks the transaction every BUS cycle.
  initial begin
    bus_t        cur;
    bit          active;
    int unsigned n;
    active = 0; n = 0;
    bus_ack = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clock);
      if (bus_req) begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_bus_req: actual bus_req=1, expected 0 (addr 0x%08h)", bus_addr);
            cur.addr = bus_addr; cur.sel = bus_sel; cur.wdata = bus_wdata;
            cur.we = bus_we; cur.delay = 0; cur.rdata = '0;
          end else begin
            cur = bus_q.pop_front();
          end
          active = 1; n = 0;
        end
        check("bus_addr", bus_addr, cur.addr);
        check("bus_sel", 32'(bus_sel), 32'(cur.sel));
        check("bus_we", 32'(bus_we), 32'(cur.we));
        if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
        if (n == cur.delay) begin
          bus_ack = 1'b1; bus_rdata = cur.rdata;
        end else begin
          bus_ack = 1'b0; bus_rdata = $urandom;
        end
        n++;
      end else begin
        active = 0;
        bus_ack = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
      end
    end
  end

  // Pulse monitor.
  initial begin
    pulse_t e;
    forever begin
      @(negedge clock);
      #2;
      if (resp_valid || exc_valid) begin
        if (sb_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_pulse: actual resp_valid=%0b exc_valid=%0b, expected none", resp_valid, exc_valid);
        end else begin
          e = sb_q.pop_front();
          check("pulse_is_exc", 32'(exc_valid), 32'(e.is_exc));
          check("pulse_is_resp", 32'(resp_valid), 32'(!e.is_exc));
          if (e.is_exc) begin
            check("exc_code", 32'(exc_code), 32'(e.code));
            check("exc_badvaddr", exc_badvaddr, e.badvaddr);
            check("exc_no_bus_req", 32'(bus_req), 32'd0);
          end else begin
            check("resp_rdata", resp_rdata, e.data);
          end
          check("latency", cyc - accept_cyc, e.lat);
        end
      end
    end
  end

  // fmode: 0 none, 1 flush in XLATE, 2 flush in first BUS cycle, 3 flush in RESP, 4 flush in IDLE first.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sg,
                        input logic [31:0] va, input logic [31:0] wd,
                        input logic tv, input logic tm, input logic [31:0] xm,
                        input int unsigned delay, input logic [31:0] rdata,
                        input int unsigned fmode_in);
    int unsigned nbytes, off, k, fmode;
    logic [31:0] pa, mask, val, selw;
    bit pulse, busx, done;
    pulse_t e;
    bus_t b;
    fmode  = fmode_in;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    pa     = va ^ xm;
    off    = pa % 4;
    pulse  = 1; busx = 0;
    e.is_exc = 1; e.data = '0; e.code = '0; e.badvaddr = va; e.lat = 2;
    if ((va % nbytes) != 0) begin
      e.code = we ? 5'd5 : 5'd4;
    end else if (!tv) begin
      e.code = tm ? (we ? 5'd3 : 5'd2) : 5'd1;
    end else begin
      busx    = 1;
      b.addr  = pa & 32'hFFFF_FFFC;
      selw    = ((32'd1 << nbytes) - 1) << off;
      b.sel   = selw[3:0];
      b.wdata = (nbytes == 1) ? {24'd0, wd[7:0]} * 32'h0101_0101 :
                (nbytes == 2) ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
      b.we    = we;
      b.delay = delay;
      b.rdata = rdata;
      mask    = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 1;
      val     = (rdata >> (8 * off)) & mask;
      if (sg && val[8 * nbytes - 1]) val = val | ~mask;
      if (delay >= NEVER) begin
        e.code = 5'd7; e.lat = 2 + TMO;
      end else begin
        e.is_exc = 0; e.data = we ? 32'd0 : val; e.lat = 3 + delay;
      end
    end
    if (fmode == 1) begin
      pulse = 0; busx = 0;
    end else if (fmode == 2 || fmode == 3) begin
      if (busx) pulse = 0; else fmode = 0;
    end

    @(negedge clock);
    tlb_valid = tv; tlb_miss = tm; tlb_xor = xm; flush = 1'b0;
    req_we = we; req_size = size; req_signed = sg; req_wdata = wd;
    if (fmode == 4) begin
      req_vaddr = ~va; req_valid = 1'b1; flush = 1'b1;
      #1 check("stall_flush_idle", 32'(stall), 32'd0);
      @(negedge clock);
      flush = 1'b0;
    end
    req_vaddr = va; req_valid = 1'b1;
    #1 check("stall_accept", 32'(stall), 32'd1);
    accept_cyc = cyc;
    if (busx) bus_q.push_back(b);
    if (pulse) sb_q.push_back(e);
    @(negedge clock);
    req_valid = 1'b0; req_vaddr = $urandom; req_wdata = $urandom; req_we = ~we;
    check("tlb_vaddr", tlb_vaddr, va);
    check("tlb_we", 32'(tlb_we), 32'(we));
    k = 1; done = 0;
    while (!done && k < 60) begin
      flush = (fmode == 1 && k == 1) || (fmode == 2 && k == 2) || (fmode == 3 && k == 3 + delay);
      #3;
      if (!stall && !bus_req && sb_q.size() == 0 && bus_q.size() == 0) done = 1;
      else begin
        @(negedge clock);
        k++;
      end
    end
    check("request_complete", 32'(done), 32'd1);
    if (!done) begin
      sb_q.delete(); bus_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we, sg, tv, tm;
    logic [1:0]  sz;
    logic [31:0] va, tmp;
    int unsigned rv, fm;
    bus_t        b;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_signed = 1'b0;
    req_vaddr = '0; req_wdata = '0; flush = 1'b0; tlb_valid = 1'b1; tlb_miss = 1'b0; tlb_xor = '0;
    repeat (3) @(negedge clock);
    #1 check_all_zero("reset");
    reset = 1'b0;

    do_req(1'b0, 2'd2, 1'b0, 32'h8000_0104, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 0, 32'hCAFE_F00D, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_1002, 32'h0, 1'b1, 1'b0, 32'h0, 0, 32'h0080_0000, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_1002, 32'h0, 1'b1, 1'b0, 32'h0, 0, 32'h0080_0000, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h0000_1003, 32'h1234, 1'b1, 1'b0, 32'h0, 0, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0040_2000, 32'h0, 1'b0, 1'b1, 32'h0, 0, 32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h0040_2000, 32'h55AA_33CC, 1'b0, 1'b0, 32'h0, 0, 32'h0, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h0000_00A5, 1'b1, 1'b0, 32'h0001_0000, 2, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0, 1'b1, 1'b0, 32'h0, 4, 32'h1111_2222, 2);
    do_req(1'b0, 2'd1, 1'b1, 32'h0000_3002, 32'h0, 1'b1, 1'b0, 32'h0, 0, 32'h8001_0000, 0);

    // Reset while the bus transaction is outstanding.
    @(negedge clock);
    tlb_valid = 1'b1; tlb_miss = 1'b0; tlb_xor = '0; flush = 1'b0;
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_vaddr = 32'h0000_4000; req_valid = 1'b1;
    b.addr = 32'h0000_4000; b.sel = 4'hF; b.wdata = '0; b.we = 1'b0; b.delay = NEVER; b.rdata = '0;
    bus_q.push_back(b);
    @(negedge clock); req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("bus_req_before_reset", 32'(bus_req), 32'd1);
    reset = 1'b1; req_valid = 1'b1;
    @(negedge clock);
    #1 check_all_zero("reset_mid_bus");
    reset = 1'b0; req_valid = 1'b0; bus_q.delete();

`ifdef BUS_TIMEOUT_EN
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_5004, 32'h0, 1'b1, 1'b0, 32'h0, NEVER, 32'h0, 0);
`endif

    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      va = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) va[0] = 1'b0;
        else if (sz != 2'd0) va[1:0] = 2'b00;
      end
      rv = $urandom_range(0, 9);
      tv = (rv < 8);
      tm = (rv == 8);
      tmp = $urandom;
      fm = $urandom_range(0, 9);
      fm = (fm < 6) ? 0 : fm - 5;
      do_req(we, sz, sg, va, $urandom, tv, tm, {tmp[31:12], 12'd0},
             $urandom_range(0, 4), $urandom, fm);
    end

    @(negedge clock);
    flush = 1'b0;
    repeat (4) @(negedge clock);
    check("scoreboard_drained", 32'(sb_q.size() + bus_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_xlate_ctrl.md
Name: mem_xlate_ctrl

Overview:
- Memory-stage access controller that sits directly upstream of the TLB. It accepts one load/store request from the MEM pipeline stage and drives the TLB's virtual address and write-enable inputs.
- It consumes the TLB's PhysicalAddress/ValidAddress/isMiss results, raises MIPS address/TLB exceptions, and otherwise runs a single data-bus transaction with a req/ack handshake.
- It stalls the pipeline until the response or exception is delivered.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for bus_ack before a bus error; used only with the optional feature.

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage presents a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- req_signed  in  1  sign-extend load data
- req_vaddr  in  32  virtual address
- req_wdata  in  32  store data, right-aligned
- flush  in  1  pipeline flush from the exception unit
- stall  out  1  hold the MEM stage
- tlb_vaddr  out  32  to TLB VirtualAddress
- tlb_we  out  1  to TLB WriteEnable
- tlb_paddr  in  32  from TLB PhysicalAddress
- tlb_valid  in  1  from TLB ValidAddress
- tlb_miss  in  1  from TLB isMiss
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  bus write
- bus_addr  out  32  physical word address ({paddr[31:2],2'b00})
- bus_sel  out  4  byte lane enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  one-cycle bus completion
- bus_rdata  in  32  read data, valid with ack
- resp_valid  out  1  one-cycle pulse: load data / store done
- resp_rdata  out  32  extended load data
- exc_valid  out  1  one-cycle exception pulse
- exc_code  out  5  CP0 ExcCode
- exc_badvaddr  out  32  faulting virtual address

Behaviour:
- Reset (synchronous): state=IDLE; every output is 0 (bus_req, stall, resp_valid, exc_valid, exc_code, exc_badvaddr, resp_rdata, bus_* and tlb_* all 0).
- Request capture: in IDLE with req_valid=1 and flush=0, latch vaddr/we/size/signed/wdata and go to XLATE.
- stall is asserted combinationally in the accept cycle and stays asserted until the cycle of resp_valid/exc_valid, inclusive of neither. The MEM stage advances on the pulse cycle.
- tlb_vaddr/tlb_we are driven from the latched request. The TLB is combinational, so its result is sampled in XLATE (1 cycle).
- XLATE checks, in priority order:
  1. Misalignment (half with vaddr[0]≠0, word with vaddr[1:0]≠0) → exc 4 (AdEL, load) or 5 (AdES, store).
  2. tlb_valid=0 & tlb_miss=1 → exc 2 (TLBL) or 3 (TLBS).
  3. tlb_valid=0 & tlb_miss=0 (store to clean page) → exc 1 (Mod).
  4. Otherwise latch tlb_paddr and go to BUS.
- Exception: exc_valid=1 for exactly one cycle with exc_badvaddr=latched vaddr; next state is IDLE. No bus activity occurs.
- BUS:
  - bus_req=1, with address/sel/wdata stable until ack.
  - bus_sel: byte = 1<<pa[1:0]; half = 0011 or 1100; word = 1111.
  - Store data is replicated (byte ×4, half ×2).
  - On bus_ack, go to RESP.
- RESP:
  - Select the lane from bus_rdata by pa[1:0]; zero- or sign-extend per req_signed.
  - resp_valid=1 for one cycle, then IDLE.
  - Store: resp_valid pulses with resp_rdata=0.
- Minimum latency: accept → resp_valid is 3 cycles with same-cycle ack (XLATE, BUS, RESP).
- A new request may be accepted in the cycle after the pulse.
- flush:
  - In IDLE: the request is not accepted.
  - In XLATE: abort to IDLE with no exception and no bus request.
  - In BUS: the transaction cannot be abandoned. The controller waits for ack, then returns to IDLE with no resp_valid. A flush flag is held until then.
  - In RESP: the pulse is suppressed.
- bus_ack outside BUS is ignored.

Optional Feature:
- BUS_TIMEOUT_EN defined: an 8+ bit counter runs in BUS. After TIMEOUT_CYCLES cycles without ack, the controller:
  - drops bus_req;
  - raises exc_valid with exc_code 7 (DBE) and exc_badvaddr=vaddr;
  - returns to IDLE.
  The counter clears on entry to BUS.
- BUS_TIMEOUT_EN undefined: the controller waits indefinitely; there is no counter.

Decomposition:
- Shared package holds:
  - ExcCode constants EXC_MOD=1, EXC_TLBL=2, EXC_TLBS=3, EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7;
  - size encodings SIZE_B/H/W;
  - the state enum IDLE/XLATE/BUS/RESP.
- One sub-module, mem_lane_align, is natural: combinational bus_sel/wdata replication and load extraction/extension.

Test Plan:
- Word load, vaddr 0x8000_0104 (kseg, TLB passes paddr 0x0000_0104), ack in same cycle → bus_addr 0x104, sel 1111, resp_valid on the 3rd cycle after accept.
- Signed byte load, vaddr[1:0]=2, bus_rdata 0x0080_0000 → resp_rdata 0xFFFF_FF80. Unsigned → 0x0000_0080.
- Half store, vaddr 0x0000_1003 → exc_valid, exc_code 5, badvaddr 0x0000_1003, bus_req never asserted.
- TLB returns valid=0, miss=1 on a load at 0x0040_2000 → exc_code 2. Store with valid=0, miss=0 → exc_code 1.
- flush during BUS with ack delayed 4 cycles → bus_req held until ack, no resp_valid; next request accepted the cycle after.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack never arrives → exc_code 7 after 8 BUS cycles, bus_req drops. Reset asserted mid-BUS → all outputs 0 next cycle.
